lcg_search_ctrl: RTL and testbench
==================================

LCG_SEARCH_CTRL -- requirements
Module: lcg_search_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data width of all LCG values, seeds and counters.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 start  input  1  pulse; requests a search with the current config inputs.
REQ-005 abort  input  1  terminates an active search.
REQ-006 MODULUS, MULTIPLIER, INCREMENT  input  WIDTH each  LCG m, a, c.
REQ-007 expected_v0, expected_v1, expected_v2  input  WIDTH each  target output sequence.
REQ-008 seed_lo, seed_hi  input  WIDTH each  inclusive seed search range.
REQ-009 busy  output  1  search in progress.
REQ-010 found  output  1  sticky; a matching seed was found.
REQ-011 exhausted  output  1  sticky; range fully scanned with no match.
REQ-012 error  output  1  sticky; rejected config (MODULUS==0 or seed_lo>seed_hi).
REQ-013 valid_seed  output  WIDTH  matching seed; valid while found==1.
REQ-014 seeds_tried  output  WIDTH  count of seeds fully rejected or matched in the current search.

Function
REQ-015 Step function SHALL be v' = (v*MULTIPLIER + INCREMENT) mod MODULUS, computed in 2*WIDTH bits with no truncation before the mod.
REQ-016 FSM states SHALL be IDLE, S0, S1, S2, S3, DONE.
REQ-017 IDLE + start: latch all config/expected/range inputs; on bad config go DONE with error=1, else seed<=seed_lo, clear found/exhausted/error/seeds_tried, go S0.
REQ-018 S0 SHALL issue current seed to the step unit; next state S1.
REQ-019 S1 SHALL compare step result with expected_v0: match -> issue result, go S2; mismatch -> reject seed.
REQ-020 S2 SHALL compare with expected_v1: match -> issue result, go S3; mismatch -> reject seed.
REQ-021 S3 SHALL compare with expected_v2: match -> valid_seed<=seed, found<=1, seeds_tried++, go DONE; mismatch -> reject seed.
REQ-022 Reject seed SHALL increment seeds_tried; if seed==seed_hi set exhausted and go DONE, else seed++ and go S0.
REQ-023 Search SHALL stop at the first (lowest) matching seed; rejected seeds cost 2, 3 or 4 cycles.
REQ-024 seed==all-ones with seed_hi==all-ones SHALL end in exhausted, never wrap to 0.
REQ-025 busy SHALL be 1 in S0..S3, 0 in IDLE and DONE.
REQ-026 start while busy SHALL be ignored; config input changes while busy SHALL have no effect.
REQ-027 abort in S0..S3 SHALL go IDLE next cycle, leaving found/exhausted=0 and seeds_tried frozen; abort outside S0..S3 has no effect; abort wins over a simultaneous match.
REQ-028 DONE SHALL hold results; start in DONE SHALL behave as start in IDLE.

Reset
REQ-029 RST SHALL force IDLE, busy=found=exhausted=error=0, valid_seed=0, seeds_tried=0, seed=0, regardless of state; RST wins over start/abort.

Structure
REQ-030 FSM state encoding and WIDTH default SHALL live in shared package lcg_pkg.
REQ-031 Step datapath SHALL be sub-module lcg_step (inputs v, a, c, m; registered output, latency 1 cycle).
REQ-032 No other sub-modules; all compare/sequencing logic in lcg_search_ctrl.

Verification
REQ-033 m=993441, a=4001, c=60211, exp=444307/466569/127141, range 0..200 -> found=1, valid_seed=96, seeds_tried=97, busy low within 200 cycles.
REQ-034 Same config, range 0..50 -> exhausted=1, found=0, seeds_tried=51.
REQ-035 MODULUS=0 or seed_lo=10, seed_hi=5 -> error=1 within 2 cycles, busy never asserted.
REQ-036 Abort 20 cycles after start of REQ-033 search -> IDLE next cycle, found=0; restart then completes as REQ-033.
REQ-037 RST asserted mid-search, then start pulsed during busy -> all outputs zero after RST; extra start ignored, result as REQ-033.
REQ-038 Range 0xFFFFFFFE..0xFFFFFFFF, non-matching targets -> exhausted=1, seeds_tried=2, no wrap.

Source files
------------

// File: rtl/lcg_pkg.sv
// Shared definitions for the LCG seed-search controller: default data width
// and the search FSM state encoding.
package lcg_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/lcg_search_ctrl_if.sv
// Command/config/result bundle between a requester (master) and the
// LCG seed-search controller (slave).
interface lcg_search_ctrl_if #(
    parameter int WIDTH = lcg_pkg::WIDTH_DEF
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] MODULUS;
    logic [WIDTH-1:0] MULTIPLIER;
    logic [WIDTH-1:0] INCREMENT;
    logic [WIDTH-1:0] expected_v0;
    logic [WIDTH-1:0] expected_v1;
    logic [WIDTH-1:0] expected_v2;
    logic [WIDTH-1:0] seed_lo;
    logic [WIDTH-1:0] seed_hi;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic             error;
    logic [WIDTH-1:0] valid_seed;
    logic [WIDTH-1:0] seeds_tried;

    modport master (
        output start, abort, MODULUS, MULTIPLIER, INCREMENT,
               expected_v0, expected_v1, expected_v2, seed_lo, seed_hi,
        input  busy, found, exhausted, error, valid_seed, seeds_tried
    );

    modport slave (
        input  start, abort, MODULUS, MULTIPLIER, INCREMENT,
               expected_v0, expected_v1, expected_v2, seed_lo, seed_hi,
        output busy, found, exhausted, error, valid_seed, seeds_tried
    );
endinterface

// File: rtl/lcg_step.sv
// One LCG step v' = (v*a + c) mod m, evaluated at full 2*WIDTH precision
// and registered (latency 1).
module lcg_step #(
    parameter int WIDTH = lcg_pkg::WIDTH_DEF
) (
    input  logic             CLK,
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] v_next_p1
);

    // v*a + c cannot exceed 2^(2W) - 2^W, so the wide sum never overflows.
    // m==0 is rejected upstream; return 0 to keep the divider defined.
    function automatic logic [WIDTH-1:0] step_mod(
        input logic [WIDTH-1:0] vv, input logic [WIDTH-1:0] aa,
        input logic [WIDTH-1:0] cc, input logic [WIDTH-1:0] mm
    );
        logic [2*WIDTH-1:0] sum;
        sum = {{WIDTH{1'b0}}, vv} * {{WIDTH{1'b0}}, aa} + {{WIDTH{1'b0}}, cc};
        if (mm == '0) return '0;
        return WIDTH'(sum % {{WIDTH{1'b0}}, mm});
    endfunction

    // Stage p0 -> p1: register the stepped value.
    always_ff @(posedge CLK) begin
        v_next_p1 <= step_mod(v, a, c, m);
    end

endmodule

// File: rtl/lcg_search_ctrl.sv
// Scans seeds seed_lo..seed_hi for the lowest one whose first three LCG
// outputs equal expected_v0..v2. A seed is rejected at the first mismatching
// output, so rejects cost 2, 3 or 4 cycles.
module lcg_search_ctrl
    import lcg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic               CLK,
    input logic               RST,
    lcg_search_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, a_q, c_q, e0_q, e1_q, e2_q, hi_q;
    logic [WIDTH-1:0] seed_q, seeds_tried_q, valid_seed_q;
    logic             found_q, exhausted_q, error_q;
    logic [WIDTH-1:0] step_v, step_out_p1;
    logic             cfg_bad, load, set_err, reject, accept;

    lcg_step #(.WIDTH(WIDTH)) u_step (
        .CLK       (CLK),
        .v         (step_v),
        .a         (a_q),
        .c         (c_q),
        .m         (m_q),
        .v_next_p1 (step_out_p1)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle control strobes; abort pre-empts any compare.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_err = 1'b0;
        reject  = 1'b0;
        accept  = 1'b0;
        step_v  = (state_q == S0) ? seed_q : step_out_p1;
        cfg_bad = (bus.MODULUS == '0) || (bus.seed_lo > bus.seed_hi);
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (cfg_bad) begin
                        set_err = 1'b1;
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = S0;
                    end
                end
            end
            S0: state_d = bus.abort ? IDLE : S1;
            S1: begin
                if (bus.abort)                state_d = IDLE;
                else if (step_out_p1 == e0_q) state_d = S2;
                else                          reject  = 1'b1;
            end
            S2: begin
                if (bus.abort)                state_d = IDLE;
                else if (step_out_p1 == e1_q) state_d = S3;
                else                          reject  = 1'b1;
            end
            S3: begin
                if (bus.abort) state_d = IDLE;
                else if (step_out_p1 == e2_q) begin
                    accept  = 1'b1;
                    state_d = DONE;
                end else begin
                    reject  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reject) state_d = (seed_q == hi_q) ? DONE : S0;
    end

    // Configuration snapshot taken when a search request is accepted.
    always_ff @(posedge CLK) begin
        if (load || set_err) begin
            m_q  <= bus.MODULUS;
            a_q  <= bus.MULTIPLIER;
            c_q  <= bus.INCREMENT;
            e0_q <= bus.expected_v0;
            e1_q <= bus.expected_v1;
            e2_q <= bus.expected_v2;
            hi_q <= bus.seed_hi;
        end
    end

    // Seed cursor and sticky result flags; the cursor never steps past seed_hi.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seed_q        <= '0;
            seeds_tried_q <= '0;
            valid_seed_q  <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            if (load || set_err) begin
                seed_q        <= bus.seed_lo;
                seeds_tried_q <= '0;
                found_q       <= 1'b0;
                exhausted_q   <= 1'b0;
                error_q       <= set_err;
            end
            if (reject) begin
                seeds_tried_q <= seeds_tried_q + WIDTH'(1);
                if (seed_q == hi_q) exhausted_q <= 1'b1;
                else                seed_q      <= seed_q + WIDTH'(1);
            end
            if (accept) begin
                seeds_tried_q <= seeds_tried_q + WIDTH'(1);
                valid_seed_q  <= seed_q;
                found_q       <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state_q == S0) || (state_q == S1) ||
                             (state_q == S2) || (state_q == S3);
    assign bus.found       = found_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.error       = error_q;
    assign bus.valid_seed  = valid_seed_q;
    assign bus.seeds_tried = seeds_tried_q;

endmodule

// File: tb/tb_lcg_search_ctrl.sv
// Directed bench for lcg_search_ctrl: table of search configurations with
// hand-computed results, plus abort / reset / ignored-start sequences.
module tb_lcg_search_ctrl;
    import lcg_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    lcg_search_ctrl_if #(.WIDTH(W)) bus ();

    lcg_search_ctrl #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] m, a, c, e0, e1, e2, lo, hi;
        logic         f, x, e;
        logic [W-1:0] seed, tried;
        int           max_cyc;
    } vec_t;

    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
        input logic [W-1:0] m, a, c, e0, e1, e2, lo, hi,
        input logic f, x, e, input logic [W-1:0] seed, tried, input int max_cyc);
        vec_t v;
        v.name = name; v.m = m; v.a = a; v.c = c;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.lo = lo; v.hi = hi;
        v.f = f; v.x = x; v.e = e; v.seed = seed; v.tried = tried; v.max_cyc = max_cyc;
        return v;
    endfunction

    task automatic apply_cfg(input vec_t v);
        bus.MODULUS = v.m; bus.MULTIPLIER = v.a; bus.INCREMENT = v.c;
        bus.expected_v0 = v.e0; bus.expected_v1 = v.e1; bus.expected_v2 = v.e2;
        bus.seed_lo = v.lo; bus.seed_hi = v.hi;
    endtask

    // Pulse start for one edge; returns at the negedge after that edge.
    task automatic pulse_start();
        @(negedge CLK) bus.start = 1'b1;
        @(negedge CLK) bus.start = 1'b0;
    endtask

    // Wait for busy to drop; cyc = edges after the start edge.
    task automatic wait_done(input string name, output int cyc, output logic saw_busy);
        logic done;
        cyc = 0; saw_busy = 1'b0; done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (bus.busy) saw_busy = 1'b1;
            else begin done = 1'b1; break; end
            @(negedge CLK);
            cyc++;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: busy still %0b after %0d cycles, required 0", name, bus.busy, cyc);
        end
    endtask

    task automatic check_result(input vec_t v);
        check({v.name, " found"},     W'(bus.found),     W'(v.f));
        check({v.name, " exhausted"}, W'(bus.exhausted), W'(v.x));
        check({v.name, " error"},     W'(bus.error),     W'(v.e));
        check({v.name, " tried"},     bus.seeds_tried,   v.tried);
        if (v.f) check({v.name, " seed"}, bus.valid_seed, v.seed);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        logic saw;
        apply_cfg(v);
        pulse_start();
        wait_done(v.name, cyc, saw);
        check_result(v);
        check({v.name, " busy_seen"}, W'(saw), W'(!v.e));
        n_chk++;
        if (cyc > v.max_cyc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required <= %0d", v.name, cyc, v.max_cyc);
        end
        repeat (3) @(negedge CLK);
        check({v.name, " hold_found"}, W'(bus.found), W'(v.f));
        check({v.name, " hold_busy"},  W'(bus.busy),  '0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"},  W'(bus.busy), '0);
        check({name, " found"}, W'(bus.found), '0);
        check({name, " exh"},   W'(bus.exhausted), '0);
        check({name, " err"},   W'(bus.error), '0);
        check({name, " seed"},  bus.valid_seed, '0);
        check({name, " tried"}, bus.seeds_tried, '0);
    endtask

    initial begin
        vec_t ref33, alt;
        int   cyc;
        logic saw;

        // m=16, a=5, c=3: seed 7 -> 6, 1, 8 (5 has inverse 13 mod 16, so 7 is unique).
        // m=2^32-5, a=c=2^32-1 (== 4 mod m): seed 2 -> 12, 52, 212; seeds 0,1 give 4, 8.
        vecs[0] = mk("v033", 993441, 4001, 60211, 444307, 466569, 127141, 0, 200, 1, 0, 0, 96, 97, 200);
        vecs[1] = mk("v034", 993441, 4001, 60211, 444307, 466569, 127141, 0, 50,  0, 1, 0, 0, 51, 2000);
        vecs[2] = mk("m0",   0,      4001, 60211, 444307, 466569, 127141, 0, 200, 0, 0, 1, 0, 0, 2);
        vecs[3] = mk("lohi", 993441, 4001, 60211, 444307, 466569, 127141, 10, 5,  0, 0, 1, 0, 0, 2);
        vecs[4] = mk("top",  993441, 4001, 60211, 32'hFFFFFFFF, 1, 2, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1, 0, 0, 2, 2000);
        vecs[5] = mk("m16",  16, 5, 3, 6, 1, 8, 0, 15, 1, 0, 0, 7, 8, 2000);
        vecs[6] = mk("m16v1", 16, 5, 3, 6, 2, 8, 0, 15, 0, 1, 0, 0, 16, 2000);
        vecs[7] = mk("m16v2", 16, 5, 3, 6, 1, 9, 0, 15, 0, 1, 0, 0, 16, 2000);
        vecs[8] = mk("one",  16, 5, 3, 6, 1, 8, 7, 7, 1, 0, 0, 7, 1, 2000);
        vecs[9] = mk("wide", 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFF, 12, 52, 212, 0, 2, 1, 0, 0, 2, 3, 2000);
        ref33 = vecs[0];
        alt   = vecs[5];

        bus.start = 1'b0; bus.abort = 1'b0;
        apply_cfg(ref33);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_all_zero("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort sampled on the 20th edge after start: seeds reject at S1 every
        // 2 cycles, so 9 seeds are counted and the 10th is mid-compare.
        apply_cfg(ref33);
        pulse_start();
        repeat (19) @(negedge CLK);
        bus.abort = 1'b1;
        @(negedge CLK) bus.abort = 1'b0;
        check("abort busy",  W'(bus.busy), '0);
        check("abort found", W'(bus.found), '0);
        check("abort exh",   W'(bus.exhausted), '0);
        check("abort tried", bus.seeds_tried, 9);
        repeat (2) @(negedge CLK);
        check("abort frozen", bus.seeds_tried, 9);
        run_vec(ref33);

        // Reset mid-search with start and abort held: reset must win.
        apply_cfg(ref33);
        pulse_start();
        repeat (10) @(negedge CLK);
        RST = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge CLK);
        RST = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        check_all_zero("rst");

        // Extra start with different config while busy must be ignored.
        pulse_start();
        repeat (5) @(negedge CLK);
        apply_cfg(alt);
        bus.start = 1'b1;
        @(negedge CLK) bus.start = 1'b0;
        wait_done("ignore", cyc, saw);
        check_result(ref33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
